// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game blocks.
//   state_t        : playback sequencer states
//   color_t        : 2-bit color index (green, red, yellow, blue)
//   led_onehot()   : color index -> one-hot LED drive
//   DEFAULT_*_MS   : durations the game core uses when nothing else is programmed
package simon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_t;

  typedef logic [1:0] color_t;

  localparam logic [9:0] DEFAULT_ON_MS  = 10'd420;
  localparam logic [9:0] DEFAULT_GAP_MS = 10'd50;

  function automatic logic [3:0] led_onehot(input color_t color);
    return 4'b0001 << color;
  endfunction

endpackage

// File: rtl/ms_timer.sv
// Millisecond interval timer.
//   clk, rst        : clock, synchronous active-high reset
//   load            : start a new interval of `ms` milliseconds (0 counts as 1)
//   ms              : interval length in milliseconds
//   ticks_per_milli : clock cycles per millisecond (0 counts as 1)
//   expired         : one-cycle pulse on the last cycle of the interval
module ms_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [9:0]  ms,
  input  logic [15:0] ticks_per_milli,
  output logic        expired
);

  logic [15:0] presc_q, presc_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        active_q, active_d;
  logic [15:0] t_m1;
  logic        wrap;

  // The period is read live, so a new ticks_per_milli applies at the next wrap.
  // The >= keeps a shrinking period from running the prescaler past its end.
  assign t_m1    = (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
  assign wrap    = (presc_q >= t_m1);
  assign expired = active_q && wrap && (cnt_q == 10'd1);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load) begin
      presc_d  = 16'd0;
      cnt_d    = (ms == 10'd0) ? 10'd1 : ms;
      active_d = 1'b1;
    end else if (active_q) begin
      if (wrap) begin
        presc_d = 16'd0;
        if (cnt_q == 10'd1) active_d = 1'b0;
        else                cnt_d    = cnt_q - 10'd1;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= 16'd0;
      cnt_q    <= 10'd0;
      active_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/simon_playback_seq.sv
// Replays the stored Simon pattern on the LEDs and speaker.
//   clk, rst            : clock, synchronous active-high reset
//   ticks_per_milli     : clock cycles per millisecond (0 counts as 1)
//   start, abort        : begin playback (IDLE only) / cancel without done
//   length, on_ms,
//   gap_ms              : step count, on-time, dark gap; latched at start
//   mem_addr, mem_data  : sequence memory read port (data one cycle after address)
//   busy, done          : not-idle flag / one-cycle completion pulse
//   led, tone_en,
//   tone_idx            : one-hot LED drive, speaker enable, tone color index
module simon_playback_seq
  import simon_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       ticks_per_milli,
  input  logic              start,
  input  logic              abort,
  input  logic [5:0]        length,
  input  logic [9:0]        on_ms,
  input  logic [9:0]        gap_ms,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_data,
  output logic              busy,
  output logic              done,
  output logic [3:0]        led,
  output logic              tone_en,
  output logic [1:0]        tone_idx
);

  state_t            state_q, state_d;
  logic [5:0]        step_q, step_d;
  logic [5:0]        len_q, len_d;
  logic [9:0]        on_q, on_d;
  logic [9:0]        gap_q, gap_d;
  color_t            color_q, color_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              busy_q, done_q, tone_en_q;
  logic [3:0]        led_q;

  logic              timer_load;
  logic [9:0]        timer_ms;
  logic              timer_expired;
  logic [5:0]        len_clamped;

  assign len_clamped = (length > 6'(MAX_LEN)) ? 6'(MAX_LEN) : length;

  ms_timer u_timer (
    .clk             (clk),
    .rst             (rst),
    .load            (timer_load),
    .ms              (timer_ms),
    .ticks_per_milli (ticks_per_milli),
    .expired         (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    len_d      = len_q;
    on_d       = on_q;
    gap_d      = gap_q;
    color_d    = color_q;
    timer_load = 1'b0;
    timer_ms   = on_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = len_clamped;
          on_d    = on_ms;
          gap_d   = gap_ms;
          step_d  = 6'd0;
          state_d = (len_clamped == 6'd0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        // mem_data answers the address presented during FETCH.
        color_d    = mem_data;
        timer_load = 1'b1;
        timer_ms   = on_q;
        state_d    = ST_PLAY;
      end
      ST_PLAY: begin
        if (timer_expired) begin
          if (step_q == len_q - 6'd1) begin
            state_d = ST_DONE;
          end else begin
            step_d = step_q + 6'd1;
            if (gap_q != 10'd0) begin
              timer_load = 1'b1;
              timer_ms   = gap_q;
              state_d    = ST_GAP;
            end else begin
              state_d = ST_FETCH;
            end
          end
        end
      end
      ST_GAP:  if (timer_expired) state_d = ST_FETCH;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort outranks timer expiry and the DONE -> IDLE step (no done pulse).
    if (abort && state_q != ST_IDLE) begin
      state_d    = ST_IDLE;
      timer_load = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    // NOTE: every flop, including the latched settings, is reset so a mid-playback
    // reset leaves nothing behind from the interrupted run.
    if (rst) begin
      state_q    <= ST_IDLE;
      step_q     <= 6'd0;
      len_q      <= 6'd0;
      on_q       <= 10'd0;
      gap_q      <= 10'd0;
      color_q    <= 2'd0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      led_q      <= 4'd0;
      tone_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      len_q      <= len_d;
      on_q       <= on_d;
      gap_q      <= gap_d;
      color_q    <= color_d;
      mem_addr_q <= ADDR_W'(step_d);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
      led_q      <= (state_d == ST_PLAY) ? led_onehot(color_d) : 4'd0;
      tone_en_q  <= (state_d == ST_PLAY);
    end
  end

  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign led      = led_q;
  assign tone_en  = tone_en_q;
  assign tone_idx = color_q;

endmodule

// File: tb/tb_simon_playback_seq.sv
module tb_simon_playback_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ticks_per_milli;
  logic        start;
  logic        abort;
  logic [5:0]  length;
  logic [9:0]  on_ms;
  logic [9:0]  gap_ms;
  logic [4:0]  mem_addr;
  logic [1:0]  mem_data;
  logic        busy;
  logic        done;
  logic [3:0]  led;
  logic        tone_en;
  logic [1:0]  tone_idx;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] mem [0:31];

  localparam int NE = 160;
  logic [3:0] exp_led   [0:NE-1];
  logic [1:0] exp_color [0:NE-1];
  logic       exp_busy  [0:NE-1];
  logic       exp_done  [0:NE-1];
  int         exp_addr  [0:NE-1];

  simon_playback_seq #(.MAX_LEN(32), .ADDR_W(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .ticks_per_milli (ticks_per_milli),
    .start           (start),
    .abort           (abort),
    .length          (length),
    .on_ms           (on_ms),
    .gap_ms          (gap_ms),
    .mem_addr        (mem_addr),
    .mem_data        (mem_data),
    .busy            (busy),
    .done            (done),
    .led             (led),
    .tone_en         (tone_en),
    .tone_idx        (tone_idx)
  );

  always #5 clk = ~clk;

  // Synchronous-read sequence memory.
  always @(posedge clk) mem_data <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model(input int from);
    for (int c = from; c < NE; c++) begin
      exp_led[c]   = 4'd0;
      exp_color[c] = 2'd0;
      exp_busy[c]  = 1'b0;
      exp_done[c]  = 1'b0;
      exp_addr[c]  = -1;
    end
  endtask

  // Expected timeline of one playback whose start is sampled at the edge
  // ending cycle `off`: FETCH, LOAD, on*t lit cycles, gap*t dark cycles
  // between steps, then one DONE cycle.
  task automatic build_model(input int n, input int t, input int on, input int gap, input int off);
    int c;
    c = off + 1;
    for (int s = 0; s < n; s++) begin
      exp_busy[c] = 1'b1; exp_addr[c] = s; c++;
      exp_busy[c] = 1'b1; c++;
      for (int k = 0; k < on * t; k++) begin
        exp_busy[c]  = 1'b1;
        exp_led[c]   = 4'b0001 << mem[s];
        exp_color[c] = mem[s];
        c++;
      end
      if (s != n - 1) begin
        for (int k = 0; k < gap * t; k++) begin
          exp_busy[c] = 1'b1; c++;
        end
      end
    end
    exp_busy[c] = 1'b1;
    exp_done[c] = 1'b1;
  endtask

  // Raise start for edge 0, then sample cycles 1..ncyc at the falling edge.
  // Bit c of smask/amask drives start/abort into the edge ending cycle c.
  task automatic run(input string tag, input int ncyc, input logic [127:0] smask,
                     input logic [127:0] amask);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      check($sformatf("%s led c%0d", tag, c), 32'(led), 32'(exp_led[c]));
      check($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'(exp_busy[c]));
      check($sformatf("%s done c%0d", tag, c), 32'(done), 32'(exp_done[c]));
      check($sformatf("%s tone_en c%0d", tag, c), 32'(tone_en), 32'(exp_led[c] != 4'd0));
      if (exp_led[c] != 4'd0)
        check($sformatf("%s tone_idx c%0d", tag, c), 32'(tone_idx), 32'(exp_color[c]));
      if (exp_addr[c] >= 0)
        check($sformatf("%s mem_addr c%0d", tag, c), 32'(mem_addr), 32'(exp_addr[c]));
      start = smask[c];
      abort = amask[c];
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst             = 1'b1;
    start           = 1'b0;
    abort           = 1'b0;
    ticks_per_milli = 16'd2;
    length          = 6'd0;
    on_ms           = 10'd0;
    gap_ms          = 10'd0;
    for (int i = 0; i < 32; i++) mem[i] = 2'((i * 3 + 1) % 4);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst led", 32'(led), 32'd0);
    check("rst tone_en", 32'(tone_en), 32'd0);
    check("rst tone_idx", 32'(tone_idx), 32'd0);
    check("rst mem_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // N=2, T=2, on=3, gap=1, memory {2,0}: lit 3-8, gap 9-10, lit 13-18, done 19.
    mem[0] = 2'd2; mem[1] = 2'd0;
    ticks_per_milli = 16'd2; length = 6'd2; on_ms = 10'd3; gap_ms = 10'd1;
    clear_model(0);
    build_model(2, 2, 3, 1, 0);
    check("model1 led c3", 32'(exp_led[3]), 32'h4);
    run("basic", 22, '0, '0);

    // Same run with start pulsed while busy (including the DONE cycle): ignored.
    run("restart_ignored", 22, (128'd1 << 5) | (128'd1 << 12) | (128'd1 << 19), '0);

    // Length 0: straight to DONE, LED never lit.
    length = 6'd0;
    clear_model(0);
    build_model(0, 2, 3, 1, 0);
    run("len0", 5, '0, '0);

    // gap_ms=0, N=3, T=1, on=2: steps separated only by FETCH+LOAD; addresses 0,1,2.
    mem[0] = 2'd1; mem[1] = 2'd3; mem[2] = 2'd2;
    ticks_per_milli = 16'd1; length = 6'd3; on_ms = 10'd2; gap_ms = 10'd0;
    clear_model(0);
    build_model(3, 1, 2, 0, 0);
    run("nogap", 16, '0, '0);

    // Abort during step 1's PLAY (cycles 10-13) at cycle 11, restart at cycle 12.
    mem[0] = 2'd3; mem[1] = 2'd1;
    ticks_per_milli = 16'd1; length = 6'd2; on_ms = 10'd4; gap_ms = 10'd1;
    clear_model(0);
    build_model(2, 1, 4, 1, 0);
    clear_model(12);
    build_model(2, 1, 4, 1, 12);
    run("abort", 30, 128'd1 << 12, 128'd1 << 11);

    // ticks_per_milli=0 behaves as 1: a single lit cycle.
    mem[0] = 2'd2;
    ticks_per_milli = 16'd0; length = 6'd1; on_ms = 10'd1; gap_ms = 10'd0;
    clear_model(0);
    build_model(1, 1, 1, 0, 0);
    run("t0", 6, '0, '0);

    // length=40 clamps to 32: addresses run to 31, done follows step 31.
    for (int i = 0; i < 32; i++) mem[i] = 2'((i * 3 + 1) % 4);
    ticks_per_milli = 16'd0; length = 6'd40; on_ms = 10'd0; gap_ms = 10'd0;
    clear_model(0);
    build_model(32, 1, 1, 0, 0);
    check("model clamp addr31", 32'(exp_addr[94]), 32'd31);
    run("clamp", 100, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
